// File: rtl/encoder_pkg.sv
// encoder_pkg: shared mode constants and clog2 helper for the priority encoders
package encoder_pkg;
    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR = 1;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/prio_search.sv
// prio_search: finds the first set bit of vec scanning upward from start, wrapping N-1 -> 0
module prio_search
    import encoder_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] index,
    output logic         found
);
    logic [W:0] s;

    // scan offsets from farthest to nearest so the nearest set bit is the last to write
    always_comb begin
        index = '0;
        found = 1'b0;
        s = '0;
        for (int k = N - 1; k >= 0; k--) begin
            s = {1'b0, start} + (W + 1)'(k);
            if (s >= (W + 1)'(N)) s = s - (W + 1)'(N);
            if (vec[s[W-1:0]]) begin
                index = s[W-1:0];
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: registered fixed/round-robin priority encoder with valid/ready handshake
// Optional onehot grant output enabled by defining PRIO_ENCODER_ONEHOT_EN.
module prio_encoder_rr
    import encoder_pkg::*;
#(
    parameter int N = 8,
    parameter int RR_MODE = 0,
    localparam int W = clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] y,
    output logic         none,
    output logic         multi,
`ifdef PRIO_ENCODER_ONEHOT_EN
    output logic [N-1:0] onehot,
`endif
    output logic         out_valid,
    input  logic         out_ready
);
    localparam logic [N-1:0] ONE = {{(N - 1){1'b0}}, 1'b1};

    logic [W-1:0] ptr;
    logic [N-1:0] rev;
    logic [N-1:0] svec;
    logic [W-1:0] start;
    logic [W-1:0] idx;
    logic [W-1:0] y_new;
    logic         found;
    logic         accept;

    prio_search #(.N(N), .W(W)) u_search (
        .vec  (svec),
        .start(start),
        .index(idx),
        .found(found)
    );

    // fixed mode searches the bit-reversed vector from 0, so the first hit is the highest index
    always_comb begin
        rev = '0;
        for (int k = 0; k < N; k++) rev[k] = i[N-1-k];
        in_ready = !out_valid || out_ready;
        accept = in_valid && in_ready;
        svec = (RR_MODE == PRIO_RR) ? i : rev;
        start = (RR_MODE == PRIO_RR) ? ptr : '0;
        y_new = !found ? '0 : (RR_MODE == PRIO_RR) ? idx : W'(N - 1) - idx;
    end

    // result register, output handshake and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y <= '0;
            none <= 1'b0;
            multi <= 1'b0;
            ptr <= '0;
`ifdef PRIO_ENCODER_ONEHOT_EN
            onehot <= '0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            y <= y_new;
            none <= !found;
            multi <= (i & (i - ONE)) != '0;
            if (RR_MODE == PRIO_RR && found) ptr <= (y_new == W'(N - 1)) ? '0 : y_new + W'(1);
`ifdef PRIO_ENCODER_ONEHOT_EN
            onehot <= found ? (ONE << y_new) : '0;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb_prio_encoder_rr: scoreboard bench driving fixed N=8, round-robin N=8 and round-robin N=5 encoders in lockstep
module tb_prio_encoder_rr;
    typedef struct packed {
        logic [2:0] y;
        logic       none;
        logic       multi;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [2:0] y0, y1, y2;
    logic       none0, none1, none2, multi0, multi1, multi2;
    logic       ov0, ov1, ov2, ir0, ir1, ir2;
`ifdef PRIO_ENCODER_ONEHOT_EN
    logic [7:0] oh0, oh1;
    logic [4:0] oh2;
`endif

    int   checks = 0;
    int   errors = 0;
    res_t q0[$], q1[$], q2[$];
    res_t r;
    bit   exp_ov = 1'b0;
    bit   exp_ir;
    int   p1 = 0, p2 = 0;

    always #5 clk = ~clk;

    prio_encoder_rr #(.N(8), .RR_MODE(0)) d0 (
        .clk(clk), .rst(rst), .i(i), .in_valid(in_valid), .in_ready(ir0),
        .y(y0), .none(none0), .multi(multi0),
`ifdef PRIO_ENCODER_ONEHOT_EN
        .onehot(oh0),
`endif
        .out_valid(ov0), .out_ready(out_ready)
    );

    prio_encoder_rr #(.N(8), .RR_MODE(1)) d1 (
        .clk(clk), .rst(rst), .i(i), .in_valid(in_valid), .in_ready(ir1),
        .y(y1), .none(none1), .multi(multi1),
`ifdef PRIO_ENCODER_ONEHOT_EN
        .onehot(oh1),
`endif
        .out_valid(ov1), .out_ready(out_ready)
    );

    prio_encoder_rr #(.N(5), .RR_MODE(1)) d2 (
        .clk(clk), .rst(rst), .i(i[4:0]), .in_valid(in_valid), .in_ready(ir2),
        .y(y2), .none(none2), .multi(multi2),
`ifdef PRIO_ENCODER_ONEHOT_EN
        .onehot(oh2),
`endif
        .out_valid(ov2), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference: fixed = highest set bit, rr = first set bit scanning up from p with wrap
    function automatic res_t model(input logic [7:0] v, input int n, input bit rr, input int p);
        res_t m;
        m.none = (v == 0);
        m.multi = $countones(v) > 1;
        m.y = '0;
        if (rr) begin
            for (int k = n - 1; k >= 0; k--) if (v[(p + k) % n]) m.y = 3'((p + k) % n);
        end else begin
            for (int k = 0; k < n; k++) if (v[k]) m.y = 3'(k);
        end
        return m;
    endfunction

    task automatic step(input logic [7:0] v, input bit iv, input bit ordy);
        @(posedge clk);
        #1;
        i = v;
        in_valid = iv;
        out_ready = ordy;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", {ov0, ov1, ov2}, 0);
            chk("rst_y", {y0, y1, y2}, 0);
            chk("rst_flags", {none0, none1, none2, multi0, multi1, multi2}, 0);
            chk("rst_ptr", {d1.ptr, d2.ptr}, 0);
`ifdef PRIO_ENCODER_ONEHOT_EN
            chk("rst_onehot", {oh0, oh1}, 0);
`endif
            q0.delete();
            q1.delete();
            q2.delete();
            exp_ov = 1'b0;
            p1 = 0;
            p2 = 0;
        end else begin
            exp_ir = !exp_ov || out_ready;
            chk("out_valid", {ov0, ov1, ov2}, {3{exp_ov}});
            chk("in_ready", {ir0, ir1, ir2}, {3{exp_ir}});
            if (exp_ov) begin
                chk("fixed8", {y0, none0, multi0}, q0[0]);
                chk("rr8", {y1, none1, multi1}, q1[0]);
                chk("rr5", {y2, none2, multi2}, q2[0]);
`ifdef PRIO_ENCODER_ONEHOT_EN
                chk("onehot_fixed8", oh0, q0[0].none ? 8'h0 : 8'(1 << q0[0].y));
                chk("onehot_rr8", oh1, q1[0].none ? 8'h0 : 8'(1 << q1[0].y));
                chk("onehot_rr5", oh2, q2[0].none ? 5'h0 : 5'(1 << q2[0].y));
`endif
                if (out_ready) begin
                    void'(q0.pop_front());
                    void'(q1.pop_front());
                    void'(q2.pop_front());
                end
            end
            if (in_valid && exp_ir) begin
                q0.push_back(model(i, 8, 1'b0, 0));
                r = model(i, 8, 1'b1, p1);
                q1.push_back(r);
                if (i != 0) p1 = (r.y + 1) % 8;
                r = model({3'b0, i[4:0]}, 5, 1'b1, p2);
                q2.push_back(r);
                if (i[4:0] != 0) p2 = (r.y + 1) % 5;
                exp_ov = 1'b1;
            end else if (out_ready) begin
                exp_ov = 1'b0;
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) step(8'hFF, 1'b1, 1'b1);
        step(8'h01, 1'b1, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        chk("ptr_after_wrap8", 16'(d1.ptr), 1);
        step(8'h24, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) step(8'(1 << k), 1'b1, 1'b1);
        step(8'h00, 1'b1, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        step(8'h0C, 1'b1, 1'b1);
        step(8'h81, 1'b1, 1'b0);
        step(8'h42, 1'b1, 1'b0);
        step(8'h18, 1'b1, 1'b0);
        step(8'h60, 1'b1, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        step(8'h10, 1'b1, 1'b1);
        step(8'h00, 1'b0, 1'b0);
        chk("ptr_after_wrap5", 16'(d2.ptr), 0);
        #2 rst = 1'b1;
        #1 chk("rst_async_out_valid", {ov0, ov1, ov2}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        i = 8'h11;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        for (int n = 0; n < 300; n++)
            step(($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        repeat (3) step(8'h00, 1'b0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
